// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and the round datapath.
//   word_t      : 32-bit AES word
//   AES_ROUNDS  : number of rounds for AES-128
//   RCON        : round constants, indexed 1..AES_ROUNDS
//   SBOX        : forward byte substitution table (shared with SubBytes)
//   ks_state_t  : key schedule FSM state encoding
//   rcon_byte() : guarded RCON lookup, returns 0 outside 1..AES_ROUNDS
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam int AES_ROUNDS = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_t;

  // Index 0 and 11..15 never occur in a legal round step; returning 0
  // keeps the lookup in range when the counter sits at the final round.
  function automatic logic [7:0] rcon_byte(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward byte S-box, purely combinational table lookup.
//   din  : input byte
//   dout : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the byte S-box to each of the four bytes of a word.
//   din  : 32-bit input word
//   dout : 32-bit word with every byte substituted
module sub_word
  import aes_pkg::*;
(
  input  word_t din,
  output word_t dout
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (din[8*i +: 8]),
      .dout (dout[8*i +: 8])
    );
  end

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion. One round key is produced per clock,
// rounds 0..10, on a valid-qualified output.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : expansion request, honoured only while busy=0
//   key_in    : cipher key, [127:96] = w0
//   busy      : expansion in progress
//   rk_valid  : rk_out / rk_round hold a round key this cycle
//   rk_round  : index of the presented round key
//   rk_out    : round key, [127:96] = first word of the round
//   done      : one-cycle pulse alongside the round-10 key
//
// Handshake: start is a request without a ready; it is accepted on any
// edge where busy=0 and dropped otherwise (never queued). The output side
// has no back-pressure: rk_valid is asserted for 11 consecutive cycles and
// the consumer takes one key per cycle.
module key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

  ks_state_t state;

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, temp;
  word_t n0, n1, n2, n3;
  logic [7:0] rcon;

  // rk_out doubles as the key register: the presented key is the seed for
  // the next round.
  assign w0 = rk_out[127:96];
  assign w1 = rk_out[95:64];
  assign w2 = rk_out[63:32];
  assign w3 = rk_out[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .din  (rot_w3),
    .dout (sub_w3)
  );

  assign rcon = rcon_byte(rk_round + 4'd1);
  assign temp = sub_w3 ^ {rcon, 24'h0};

  // Ripple XOR chain: each new word depends on the one before it.
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= KS_IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_round <= 4'd0;
      rk_out   <= 128'h0;
    end else begin
      case (state)
        KS_IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk_out   <= key_in;
            rk_round <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= KS_RUN;
          end
        end
        KS_RUN: begin
          if (rk_round == LAST_ROUND) begin
            // rk_out keeps the final key; rk_valid=0 marks it stale.
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            state    <= KS_IDLE;
          end else begin
            rk_out   <= {n0, n1, n2, n3};
            rk_round <= rk_round + 4'd1;
            done     <= (rk_round == LAST_ROUND - 4'd1);
          end
        end
        default: begin
          state    <= KS_IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] mdl [0:10];
  logic [127:0] cap [0:10];
  logic [127:0] exp_q [$];

  key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      b = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-by-word expansion into mdl[0..10].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]], sbox_ref[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  // One full run: accept key, check all 11 round keys against the
  // scoreboard queue, then check the return to idle.
  task automatic run_key(input logic [127:0] key, input bit scramble, input bit pulse10);
    logic [127:0] e;
    model_expand(key);
    exp_q.delete();
    for (int r = 0; r < 11; r++) exp_q.push_back(mdl[r]);
    start  = 1'b1;
    key_in = key;
    tick();
    start = 1'b0;
    for (int r = 0; r < 11; r++) begin
      e = exp_q.pop_front();
      cap[r] = rk_out;
      chk($sformatf("r%0d_valid", r), 128'(rk_valid), 128'(1));
      chk($sformatf("r%0d_busy", r), 128'(busy), 128'(1));
      chk($sformatf("r%0d_round", r), 128'(rk_round), 128'(r));
      chk($sformatf("r%0d_key", r), rk_out, e);
      chk($sformatf("r%0d_done", r), 128'(done), 128'(r == 10));
      if (scramble) key_in = rand128();
      if (pulse10 && r == 10) begin
        start  = 1'b1;
        key_in = rand128();
      end
      tick();
      start = 1'b0;
    end
    chk_idle("end");
    if (pulse10) begin
      tick();
      chk_idle("pulse10_after");
      tick();
      chk_idle("pulse10_after2");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k;
    int ph;

    build_sbox();

    rst    = 1'b1;
    start  = 1'b0;
    key_in = 128'h0;
    #2;
    chk_idle("reset");
    chk("reset_round", 128'(rk_round), 128'(0));
    chk("reset_rk_out", rk_out, 128'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle("post_reset_idle");

    // FIPS-197 key
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0);
    chk("fips_r0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();

    // all-zero key
    run_key(128'h0, 1'b0, 1'b0);
    chk("zero_r1", cap[1], 128'h62636363626363636263636362636363);
    chk("zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick();

    // random keys, key_in scrambled every cycle during the run
    for (int n = 0; n < 4; n++) begin
      run_key(rand128(), 1'b1, 1'b0);
      tick();
    end

    // start held high: acceptance every 12 cycles
    k = rand128();
    model_expand(k);
    start  = 1'b1;
    key_in = k;
    for (int c = 0; c < 36; c++) begin
      tick();
      ph = c % 12;
      chk($sformatf("hold_c%0d_valid", c), 128'(rk_valid), 128'(ph < 11));
      chk($sformatf("hold_c%0d_busy", c), 128'(busy), 128'(ph < 11));
      chk($sformatf("hold_c%0d_done", c), 128'(done), 128'(ph == 10));
      if (ph < 11) begin
        chk($sformatf("hold_c%0d_round", c), 128'(rk_round), 128'(ph));
        chk($sformatf("hold_c%0d_key", c), rk_out, mdl[ph]);
      end
    end
    start = 1'b0;
    tick();
    tick();
    chk_idle("hold_stop");

    // reset in the middle of a run
    k = rand128();
    model_expand(k);
    start  = 1'b1;
    key_in = k;
    tick();
    start = 1'b0;
    for (int r = 0; r < 5; r++) tick();
    chk("abort_round5", 128'(rk_round), 128'(5));
    chk("abort_key5", rk_out, mdl[5]);
    rst = 1'b1;
    #1;
    chk_idle("abort_reset");
    chk("abort_round", 128'(rk_round), 128'(0));
    chk("abort_rk_out", rk_out, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    chk_idle("abort_after");
    run_key(rand128(), 1'b0, 1'b0);
    tick();

    // start pulsed during the round-10 cycle must be ignored
    run_key(rand128(), 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
